// File: rtl/hilo_muldiv_sequencer_pkg.sv
// rtl/hilo_muldiv_sequencer_pkg.sv - op/state encodings and helpers for the HI/LO mul/div sequencer
package hilo_muldiv_sequencer_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Even encodings are the signed variants.
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_acc(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_sub(input op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_muldiv_step.sv
// rtl/hilo_muldiv_sequencer_muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module hilo_muldiv_sequencer_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
        shifted = {hi_i, lo_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand_i});
        // When the trial subtraction succeeds the remainder is below the divisor, so WIDTH bits hold it.
        diff    = shifted[WIDTH-1:0] - operand_i;
        hi_o    = add_sum[WIDTH:1];
        lo_o    = {add_sum[0], lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            hi_o = fits ? diff : shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// rtl/hilo_muldiv_sequencer.sv - iterative mul/div engine that owns the HI/LO write and stall request
module hilo_muldiv_sequencer
    import hilo_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_in_i,
    input  logic [WIDTH-1:0] lo_in_i,
    input  logic             hilo_read_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             done_o,
    output logic             hilo_write_o,
    output logic [WIDTH-1:0] hi_out_o,
    output logic [WIDTH-1:0] lo_out_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_in_q, lo_in_q;
    logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;
    logic [WIDTH-1:0] hi_out_q, lo_out_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_res_q, neg_rem_q;
    logic             busy_q, done_q, div_zero_q;

    logic             is_signed, is_div, is_acc, is_sub;
    logic [WIDTH-1:0] a_abs_d, b_abs_d, acc_hi_d, acc_lo_d, fix_hi_d, fix_lo_d;
    logic [2*WIDTH-1:0] prod_d, sum_d;
    logic             fix_dz_d;

    assign is_signed = op_is_signed(op_q);
    assign is_div    = op_is_div(op_q);
    assign is_acc    = op_is_acc(op_q);
    assign is_sub    = op_is_sub(op_q);

    hilo_muldiv_sequencer_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i  (is_div),
        .hi_i      (acc_hi_q),
        .lo_i      (acc_lo_q),
        .operand_i (opnd_q),
        .hi_o      (acc_hi_d),
        .lo_o      (acc_lo_d)
    );

    always_comb begin
        a_abs_d  = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs_d  = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        prod_d   = {acc_hi_q, acc_lo_q};
        if (neg_res_q) begin
            prod_d = -prod_d;
        end
        sum_d    = is_sub ? ({hi_in_q, lo_in_q} - prod_d) : ({hi_in_q, lo_in_q} + prod_d);
        fix_dz_d = 1'b0;
        fix_hi_d = is_acc ? sum_d[2*WIDTH-1:WIDTH] : prod_d[2*WIDTH-1:WIDTH];
        fix_lo_d = is_acc ? sum_d[WIDTH-1:0]       : prod_d[WIDTH-1:0];
        if (is_div) begin
            // Divide by zero still runs the full sequence; only the committed values are replaced.
            if (b_q == '0) begin
                fix_dz_d = 1'b1;
                fix_hi_d = a_q;
                fix_lo_d = '1;
            end else begin
                fix_hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                fix_lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            hi_in_q    <= '0;
            lo_in_q    <= '0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            hi_out_q   <= '0;
            lo_out_q   <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A flush in DONE is too late: the write is already on the bus.
            if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            op_q    <= op_e'(op_i);
                            a_q     <= a_i;
                            b_q     <= b_i;
                            hi_in_q <= hi_in_i;
                            lo_in_q <= lo_in_i;
                            busy_q  <= 1'b1;
                            state_q <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        neg_res_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_rem_q <= is_signed & a_q[WIDTH-1];
                        acc_hi_q  <= '0;
                        acc_lo_q  <= is_div ? a_abs_d : b_abs_d;
                        opnd_q    <= is_div ? b_abs_d : a_abs_d;
                        cnt_q     <= '0;
                        state_q   <= S_CALC;
                    end
                    S_CALC: begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        cnt_q    <= cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        hi_out_q   <= fix_hi_d;
                        lo_out_q   <= fix_lo_d;
                        div_zero_q <= fix_dz_d;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o       = busy_q;
    assign stall_req_o  = busy_q & (start_i | hilo_read_i);
    assign done_o       = done_q;
    assign hilo_write_o = done_q;
    assign hi_out_o     = hi_out_q;
    assign lo_out_o     = lo_out_q;
    assign div_zero_o   = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb/tb_hilo_muldiv_sequencer.sv - scoreboard bench for the HI/LO mul/div sequencer
module tb_hilo_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hilo_read = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0, b = '0, hi_in = '0, lo_in = '0;
    logic          busy, stall, done, hilo_write, dz;
    logic [W-1:0]  hi_out, lo_out;

    hilo_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .op_i         (op),
        .a_i          (a),
        .b_i          (b),
        .hi_in_i      (hi_in),
        .lo_in_i      (lo_in),
        .hilo_read_i  (hilo_read),
        .abort_i      (abort),
        .busy_o       (busy),
        .stall_req_o  (stall),
        .done_o       (done),
        .hilo_write_o (hilo_write),
        .hi_out_o     (hi_out),
        .lo_out_o     (lo_out),
        .div_zero_o   (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] last_hi = '0, last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: 64-bit products and native truncating division.
    function automatic exp_t model(input logic [2:0] fop, input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic [W-1:0] fh, input logic [W-1:0] fl);
        exp_t e;
        longint sa, sb2;
        logic [63:0] prod, acc;
        e.dz = 1'b0;
        e.cyc = 0;
        e.hi = '0;
        e.lo = '0;
        if (fop == 3'd2 || fop == 3'd3) begin
            if (fb == 0) begin
                e.hi = fa; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
            end else if (fop == 3'd2) begin
                if (fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'h0;
                end else begin
                    e.lo = $signed(fa) / $signed(fb);
                    e.hi = $signed(fa) % $signed(fb);
                end
            end else begin
                e.lo = fa / fb;
                e.hi = fa % fb;
            end
        end else begin
            if (fop[0] == 1'b0) begin
                sa = $signed(fa);
                sb2 = $signed(fb);
                prod = sa * sb2;
            end else begin
                prod = 64'(fa) * 64'(fb);
            end
            acc = {fh, fl};
            if (fop >= 3'd6)      acc = acc - prod;
            else if (fop >= 3'd4) acc = acc + prod;
            else                  acc = prod;
            e.hi = acc[63:32];
            e.lo = acc[31:0];
        end
        return e;
    endfunction

    task automatic push_exp(input logic [2:0] fop, input logic [W-1:0] fa, input logic [W-1:0] fb,
                            input logic [W-1:0] fh, input logic [W-1:0] fl, input int done_cyc);
        exp_t e;
        e = model(fop, fa, fb, fh, fl);
        e.cyc = done_cyc;
        sb.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    task automatic issue(input logic [2:0] fop, input logic [W-1:0] fa, input logic [W-1:0] fb,
                         input logic [W-1:0] fh, input logic [W-1:0] fl, input bit expect_result);
        @(negedge clk);
        op = fop; a = fa; b = fb; hi_in = fh; lo_in = fl; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_result) push_exp(fop, fa, fb, fh, fl, cyc + W + 2);
    endtask

    task automatic wait_idle(input int seen);
        int n;
        n = seen;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(W + 3));
    endtask

    always @(negedge clk) begin
        if (rst_n && (done || hilo_write)) begin
            check("hilo_write_eq_done", 64'(hilo_write), 64'(done));
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("hi_out", 64'(hi_out), 64'(mon_e.hi));
                check("lo_out", 64'(lo_out), 64'(mon_e.lo));
                check("div_zero", 64'(dz), 64'(mon_e.dz));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int c0;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi_out), 64'(0));
        check("rst_lo", 64'(lo_out), 64'(0));
        check("rst_dz", 64'(dz), 64'(0));
        rst_n = 1'b1;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 1'b1);          wait_idle(0);
        issue(3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1);                wait_idle(0);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b1);          wait_idle(0);
        issue(3'd2, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1);                  wait_idle(0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);  wait_idle(0);
        issue(3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b1);          wait_idle(0);
        issue(3'd6, 32'd1, 32'd1, 32'h0, 32'h0, 1'b1);                  wait_idle(0);

        // Second request and HI/LO read while busy must stall and not be taken.
        issue(3'd1, 32'd1234, 32'd5678, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        op = 3'd3; a = 32'd99; b = 32'd3; start = 1'b1;
        #1 check("stall_on_start", 64'(stall), 64'(1));
        @(negedge clk);
        start = 1'b0; hilo_read = 1'b1;
        #1 check("stall_on_read", 64'(stall), 64'(1));
        hilo_read = 1'b0;
        #1 check("stall_quiet", 64'(stall), 64'(0));
        wait_idle(2);

        // Start held through DONE: taken on the first IDLE cycle after DONE.
        @(negedge clk);
        op = 3'd4; a = 32'h0001_0000; b = 32'h0000_0010; hi_in = 32'd7; lo_in = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        push_exp(3'd4, 32'h0001_0000, 32'h0000_0010, 32'd7, 32'd9, c0 + W + 2);
        op = 3'd3; a = 32'd1000; b = 32'd33;
        push_exp(3'd3, 32'd1000, 32'd33, 32'd7, 32'd9, c0 + 2 * W + 6);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c0 + W + 4);
        start = 1'b0;
        wait_idle(0);

        // Abort and Start together in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        #1 check("stall_idle", 64'(stall), 64'(0));
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("busy_after_abort_start", 64'(busy), 64'(0));

        // Abort in cycle 10 of a MULT.
        issue(3'd0, 32'd12345, 32'd678, 32'h0, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("busy_after_abort", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        check("hi_kept_after_abort", 64'(hi_out), 64'(last_hi));
        check("lo_kept_after_abort", 64'(lo_out), 64'(last_lo));

        // Asynchronous reset in cycle 20.
        issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_hi", 64'(hi_out), 64'(0));
        check("arst_lo", 64'(lo_out), 64'(0));
        check("arst_dz", 64'(dz), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_hi = '0;
        last_lo = '0;

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = 32'($urandom);
            endcase
            issue(rop, ra, rb, 32'($urandom), 32'($urandom), 1'b1);
            wait_idle(0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
Iterative multiply/divide engine and sequencer that owns HI/LO writes for the pipelined MIPS datapath. Accepts an operation from the EX stage, runs a multi-cycle shift-add or restoring-divide sequence, then pulses a single HI/LO write. Raises a stall request so the hazard logic can hold dependent instructions: mfhi/mflo, and a second mult/div. Replaces the single-cycle HI/LO path into the HI and LO registers.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; CALC iteration count = WIDTH.

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
Start  in  1  request; sampled only in IDLE
Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
A  in  WIDTH  rs operand (multiplicand / dividend)
B  in  WIDTH  rt operand (multiplier / divisor)
Hi_in  in  WIDTH  current HI, captured at Start (accumulate ops)
Lo_in  in  WIDTH  current LO, captured at Start
HiLo_Read  in  1  ID/EX instruction reads HI or LO
Abort  in  1  pipeline flush; cancels the current operation
Busy  out  1  state != IDLE
Stall_req  out  1  Busy & (Start | HiLo_Read)
Done  out  1  one-cycle pulse in DONE
HiLo_Write  out  1  equals Done; write enable to HI/LO
Hi_out  out  WIDTH  result HI, held until the next Done
Lo_out  out  WIDTH  result LO, held until the next Done
DivZero  out  1  valid with Done; divide with B == 0

Behaviour:
- Reset (Rst low, async): state IDLE; Busy, Done, HiLo_Write, DivZero = 0; Hi_out, Lo_out = 0; internal accumulators = 0.
- FSM: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on Start & !Abort, latch Op, A, B, Hi_in, Lo_in, then go to PREP.
- PREP (1 cycle): signed ops take absolute values and record result sign (product: sa^sb; quotient: sa^sb; remainder: sa). Iteration counter = 0.
- CALC (WIDTH cycles): one step per cycle.
  - Multiply: add multiplicand to the upper half if the multiplier LSB is set, then shift right 1 (2*WIDTH-bit product register).
  - Divide: shift remainder:quotient left 1, trial-subtract divisor, set quotient bit if the result is non-negative.
  - Exit when counter == WIDTH-1.
- FIX (1 cycle):
  - Apply sign correction.
  - MADD*/MSUB*: add or subtract the 2*WIDTH-bit product to/from {Hi_in,Lo_in}, modulo 2^(2*WIDTH).
  - Divide: Lo = quotient, Hi = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- DONE (1 cycle): Done = HiLo_Write = 1; Hi_out/Lo_out/DivZero update on entry.
- Latency: Start sampled at edge t; Done is high during cycle t+WIDTH+3 (35 for WIDTH=32). Fixed for all ops, including divide-by-zero.
- Divide by zero: full latency; Lo = all ones, Hi = A; DivZero = 1. Otherwise DivZero = 0 at Done.
- DIV overflow (most-negative / -1): Lo = 0x80000000, Hi = 0.
- Start while Busy: ignored; Stall_req high; the pipeline must hold the instruction until IDLE.
- Start in the DONE cycle: ignored. Earliest accept is the following IDLE cycle.
- Abort in any non-IDLE state: next state IDLE, no Done, Hi_out/Lo_out unchanged.
- Abort together with Start in IDLE: Abort wins, nothing accepted.
- Abort during DONE: write still occurs; the result is already committed.
- Rst low mid-operation: immediate return to reset values; no partial write.

Decomposition:
- Shared package: Op encodings (OP_MULT..OP_MSUBU); state encoding (S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE); WIDTH default.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-shift / trial-subtract-shift) selected by a mul/div flag. The FSM, counter and registers stay in the top.

Test Plan:
- MULT A=0xFFFFFFFE, B=3, Start at edge 0 -> Done and HiLo_Write high only in cycle 35; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; Busy high cycles 1-35.
- DIVU A=100, B=7 -> Lo=14, Hi=2, DivZero=0. DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV A=5, B=0 -> Done at cycle 35; Lo=0xFFFFFFFF, Hi=5, DivZero=1. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MADDU Hi_in=0, Lo_in=0xFFFFFFFF, A=1, B=1 -> Hi=1, Lo=0. MSUB Hi_in=0, Lo_in=0, A=1, B=1 -> Hi=Lo=0xFFFFFFFF.
- Abort at cycle 10 of a MULT -> Busy low at cycle 11, no Done, Hi/Lo unchanged. Rst pulled low at cycle 20 -> all outputs 0 asynchronously.
- While Busy: second Start and HiLo_Read each raise Stall_req the same cycle, and the second Start is not accepted. Start held through the DONE cycle -> accepted on the following IDLE cycle, Done 35 cycles later.
